// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: instruction-memory request/ack and the decode handshake,
// including the branch inputs sampled by the fetch controller on accept.
interface fetch_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_out;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic                  PCsrc;
  logic [DATA_WIDTH-1:0] ImmOp;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, PCsrc, ImmOp
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_ack, imem_rdata, instr_ready, PCsrc, ImmOp
  );
endinterface

// File: rtl/fetch_ctrl.sv
// PC sequencer and single-entry instruction fetch buffer: one outstanding
// memory request, valid/ready hand-off to decode, branch and misalignment trap.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | one cycle after reset, no request
// REQ   | fetch of PC_out outstanding, waiting for ack
// HOLD  | instruction buffered, offered to decode
// FAULT | misaligned branch target trapped, reset only
module fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_ctrl_if.master          bus,
  output logic [DATA_WIDTH-1:0] PC_out,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  accept;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] instr_out_q;
  logic [DATA_WIDTH-1:0] instr_pc_q;

  assign accept     = (state == HOLD) && bus.instr_ready;
  assign target     = instr_pc_q + (bus.PCsrc ? bus.ImmOp : DATA_WIDTH'(4));
  assign misaligned = (target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (bus.imem_ack) state_nxt = HOLD;
      HOLD:    if (accept) state_nxt = misaligned ? FAULT : REQ;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode only the registered state, never the inputs.
  always_comb begin
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    fault           = 1'b0;
    case (state)
      REQ:     bus.imem_req    = 1'b1;
      HOLD:    bus.instr_valid = 1'b1;
      FAULT:   fault           = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_out      <= RESET_PC;
      instr_out_q <= '0;
      instr_pc_q  <= '0;
      instr_count <= '0;
    end else begin
      if ((state == REQ) && bus.imem_ack) begin
        instr_out_q <= bus.imem_rdata;
        instr_pc_q  <= PC_out;
      end
      if (accept) begin
        instr_count <= instr_count + DATA_WIDTH'(1);
        if (!misaligned) begin
          PC_out <= target;
        end
      end
    end
  end

  assign bus.imem_addr = PC_out;
  assign bus.instr_out = instr_out_q;
  assign bus.instr_pc  = instr_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a memory model answers requests, the main
// thread plays decode and pushes expectations, a monitor pops and compares.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] PC_out;
  logic        fault;
  logic [31:0] instr_count;

  fetch_ctrl_if #(.DATA_WIDTH(32)) bus ();

  fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .PC_out      (PC_out),
    .fault       (fault),
    .instr_count (instr_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_instr[$];

  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        man_ack;
  logic [31:0] man_rdata;
  bit          wait_en;
  bit          hold_en;
  int          wait_cnt;
  int          last_req_cycles;
  int          last_accept_cyc;

  assign bus.imem_ack   = mem_ack | man_ack;
  assign bus.imem_rdata = man_ack ? man_rdata : mem_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: optional 3 wait cycles at address 4, never answers address 0 when held.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (rst) begin
        wait_cnt = 0;
      end else if (bus.imem_req && !(hold_en && bus.imem_addr == 32'h0)) begin
        if (wait_en && bus.imem_addr == 32'h4 && wait_cnt < 3) begin
          wait_cnt++;
        end else begin
          mem_ack   = 1'b1;
          mem_rdata = mem_data(bus.imem_addr);
          wait_cnt  = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.imem_req && bus.imem_ack) begin
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fetch: got addr %h expected no fetch", bus.imem_addr);
          end else begin
            chk("fetch_addr", bus.imem_addr, exp_addr.pop_front());
          end
        end
        if (bus.instr_valid && bus.instr_ready) begin
          if (exp_instr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: got pc %h expected no accept", bus.instr_pc);
          end else begin
            logic [63:0] e;
            e = exp_instr.pop_front();
            chk("accept_instr", bus.instr_out, e[63:32]);
            chk("accept_pc", bus.instr_pc, e[31:0]);
          end
        end
      end
    end
  end

  task automatic check_reset();
    chk("rst_PC_out", PC_out, 32'h0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_instr_out", bus.instr_out, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_instr_count", instr_count, 32'h0);
  endtask

  // Called at posedge+1: waits for the instruction at exp_pc, optionally stalls,
  // then accepts it with the given branch inputs and checks the resulting PC.
  task automatic do_accept(input logic [31:0] exp_pc, input logic src,
                           input logic [31:0] imm, input logic [31:0] next_pc,
                           input int stall, input bit exp_fault, input bit push_next);
    int          n;
    bit          addr_bad;
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    n        = 0;
    addr_bad = 0;
    last_req_cycles = 0;
    exp_instr.push_back({mem_data(exp_pc), exp_pc});
    while (!bus.instr_valid && n < 40) begin
      if (bus.imem_req) begin
        last_req_cycles++;
        if (bus.imem_addr !== exp_pc) addr_bad = 1;
      end
      n++;
      @(posedge clk);
      #1;
    end
    if (!bus.instr_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no instr_valid expected instr at %h", exp_pc);
      void'(exp_instr.pop_back());
      return;
    end
    chk("req_addr_held", {31'b0, addr_bad}, 32'h0);
    chk("valid_pc", bus.instr_pc, exp_pc);
    held_instr = bus.instr_out;
    held_pc    = bus.instr_pc;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_instr", bus.instr_out, held_instr);
      chk("stall_pc", bus.instr_pc, held_pc);
      chk("stall_no_req", {31'b0, bus.imem_req}, 32'h0);
    end
    if (push_next) exp_addr.push_back(next_pc);
    bus.instr_ready = 1'b1;
    bus.PCsrc       = src;
    bus.ImmOp       = imm;
    @(posedge clk);
    last_accept_cyc = cyc;
    #1;
    bus.instr_ready = 1'b0;
    bus.PCsrc       = 1'b1;
    bus.ImmOp       = 32'h3;
    chk("next_PC_out", PC_out, exp_fault ? exp_pc : next_pc);
    chk("fault_after_accept", {31'b0, fault}, {31'b0, exp_fault});
  endtask

  initial begin
    int prev;
    rst             = 1'b1;
    man_ack         = 1'b0;
    man_rdata       = '0;
    wait_en         = 0;
    hold_en         = 0;
    bus.instr_ready = 1'b0;
    bus.PCsrc       = 1'b0;
    bus.ImmOp       = '0;
    #12;
    check_reset();

    exp_addr.push_back(32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_req", {31'b0, bus.imem_req}, 32'h1);

    do_accept(32'h0, 1'b0, 32'h0, 32'h4, 0, 0, 1);
    prev = last_accept_cyc;
    for (int k = 1; k < 4; k++) begin
      logic [31:0] pc;
      pc = 32'(k * 4);
      do_accept(pc, 1'b0, 32'h0, pc + 32'h4, 0, 0, 1);
      chk("accept_spacing", 32'(last_accept_cyc - prev), 32'd2);
      prev = last_accept_cyc;
    end
    chk("count_after_4", instr_count, 32'd4);

    do_accept(32'h10, 1'b1, 32'hFFFF_FFF8, 32'h08, 5, 0, 1);
    do_accept(32'h08, 1'b0, 32'h0, 32'h0C, 0, 0, 1);
    do_accept(32'h0C, 1'b0, 32'h0, 32'h10, 0, 0, 1);
    do_accept(32'h10, 1'b1, 32'h20, 32'h30, 0, 0, 1);
    do_accept(32'h30, 1'b1, 32'hFFFF_FFE0, 32'h10, 0, 0, 1);
    do_accept(32'h10, 1'b1, 32'h6, 32'h10, 0, 1, 0);
    chk("count_at_fault", instr_count, 32'd10);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("fault_no_req", {31'b0, bus.imem_req}, 32'h0);
      chk("fault_no_valid", {31'b0, bus.instr_valid}, 32'h0);
      chk("fault_sticky", {31'b0, fault}, 32'h1);
      chk("fault_PC_out", PC_out, 32'h10);
    end

    rst = 1'b1;
    #1;
    check_reset();
    wait_en = 1;
    exp_addr.push_back(32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_accept(32'h0, 1'b0, 32'h0, 32'h4, 0, 0, 1);
    hold_en = 1;
    do_accept(32'h4, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 0, 1);
    chk("wait_req_cycles", 32'(last_req_cycles), 32'd4);
    wait_en = 0;
    do_accept(32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    chk("wrap_count", instr_count, 32'd3);

    @(posedge clk);
    #1;
    chk("pending_req", {31'b0, bus.imem_req}, 32'h1);
    chk("pending_addr", bus.imem_addr, 32'h0);
    rst = 1'b1;
    #1;
    check_reset();
    man_rdata = 32'hDEAD_BEEF;
    man_ack   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    chk("late_ack_req", {31'b0, bus.imem_req}, 32'h1);
    chk("late_ack_instr", bus.instr_out, 32'h0);
    chk("late_ack_pc", bus.instr_pc, 32'h0);
    @(posedge clk);
    #1;
    chk("late_ack_no_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("late_ack_still_req", {31'b0, bus.imem_req}, 32'h1);

    chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk("instr_queue_empty", 32'(exp_instr.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the program counter and instruction-fetch path of the reduced RISC-V core. It issues one instruction-memory request at a time, buffers the returned instruction, and presents it to decode with a valid/ready handshake. When decode accepts an instruction, the block advances the PC by 4, or branches to `instr_pc + ImmOp` when `PCsrc` is set. Misaligned branch targets are trapped, and a retired-instruction counter is maintained.

## Interface
- `DATA_WIDTH`, 32: width of PC, addresses, instruction word and counter.
- `RESET_PC`, 0: PC value loaded on reset; must be 4-byte aligned.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out DATA_WIDTH: fetch address; always equals `PC_out`.
- `imem_ack` in 1: memory response valid; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in DATA_WIDTH: fetched instruction word.
- `instr_valid` out 1: buffered instruction available to decode.
- `instr_ready` in 1: decode accepts the instruction.
- `instr_out` out DATA_WIDTH: buffered instruction.
- `instr_pc` out DATA_WIDTH: address of `instr_out`.
- `PCsrc` in 1: branch taken; sampled only on accept.
- `ImmOp` in DATA_WIDTH: branch offset; sampled only on accept.
- `PC_out` out DATA_WIDTH: current fetch PC.
- `fault` out 1: misaligned branch target trapped; sticky.
- `instr_count` out DATA_WIDTH: number of accepted instructions.

## Operation
- States:
  - IDLE: post-reset, 1 cycle.
  - REQ: request outstanding.
  - HOLD: instruction buffered.
  - FAULT: terminal.
- IDLE -> REQ unconditionally on the next edge.
- REQ:
  - `imem_req`=1 and `imem_addr`=`PC_out`, both held stable until ack.
  - On `imem_ack`: latch `imem_rdata` into `instr_out` and `PC_out` into `instr_pc`, then go to HOLD.
  - Without ack: remain in REQ indefinitely.
- HOLD:
  - `instr_valid`=1 and `imem_req`=0.
  - `instr_out` and `instr_pc` are held stable until accept.
  - Accept means `instr_valid & instr_ready`.
- On accept:
  - Compute target = `instr_pc + ImmOp` if `PCsrc`, else `instr_pc + 4`.
  - Increment `instr_count`.
  - If target[1:0] != 0: set `fault`=1, do not update `PC_out`, go to FAULT.
  - Otherwise: `PC_out` <= target, go to REQ.
- FAULT: `imem_req`=0, `instr_valid`=0, `fault`=1. Only reset leaves FAULT.
- Arithmetic rules:
  - All PC arithmetic is modulo 2^DATA_WIDTH; 0xFFFF_FFFC + 4 = 0.
  - `ImmOp` is treated as two's complement, with the same modulo wrap.
  - `instr_count` wraps from all-ones to 0.
- `imem_ack` outside REQ is ignored.
- `PCsrc` and `ImmOp` outside accept are ignored.

## Timing
- Reset values, applied immediately on `rst` assertion:
  - `PC_out`=`RESET_PC`, `imem_addr`=`RESET_PC`.
  - `imem_req`=0, `instr_valid`=0, `fault`=0.
  - `instr_out`=0, `instr_pc`=0, `instr_count`=0.
  - state = IDLE.
- First edge after `rst` deasserts: enter REQ, so `imem_req`=1 from cycle 1.
- `imem_req`, `instr_valid` and `fault` are decoded from registered state only (no combinational path from inputs).
- Zero-wait memory (ack in the first REQ cycle) with decode always ready: 2 cycles per instruction, alternating REQ and HOLD.
- N wait cycles before ack add N cycles. Each stall cycle of `instr_ready`=0 in HOLD adds 1 cycle.
- The new `PC_out` and `instr_count` are visible in the cycle after accept.
- `fault` rises in the cycle after the faulting accept.
- Reset mid-request: `imem_req` drops asynchronously. The abandoned request is not retried, and a late ack arriving in IDLE is ignored.

## Test plan
- Reset with `RESET_PC`=0 and zero-wait memory returning 0x00000013, ready=1, `PCsrc`=0:
  - `imem_addr` sequence is 0, 4, 8, 12.
  - `instr_valid` pulses every 2nd cycle.
  - `instr_count`=4 after 4 accepts.
- Memory inserts 3 wait cycles at address 4:
  - `imem_req` and `imem_addr`=4 are held for 4 cycles.
  - `instr_pc`=4 appears one cycle after ack.
- `instr_ready`=0 for 5 cycles in HOLD: `instr_out` and `instr_pc` stay stable, and no new `imem_req` is issued.
- Branch: accept at `instr_pc`=0x10 with `PCsrc`=1 and `ImmOp`=0xFFFFFFF8 -> next `imem_addr`=0x08. With `ImmOp`=0x20 -> next `imem_addr`=0x30.
- Accept at `instr_pc`=0x10 with `PCsrc`=1 and `ImmOp`=0x6:
  - `fault`=1 and `PC_out` stays 0x10.
  - No further `imem_req`.
  - Reset clears `fault` and restarts at `RESET_PC`.
- Two boundary cases:
  - `PC_out`=0xFFFFFFFC with sequential accept -> `PC_out`=0.
  - Assert `rst` while in REQ, then send a late ack -> outputs are at reset values and the ack is ignored.
